// File: rtl/tqvp_prism_infilt.sv
// PRISM input conditioner: per-channel polarity inversion, programmable glitch filter,
// registered edge pulses and sticky edge flags with a level interrupt, on the TinyQV
// peripheral register bus.
module tqvp_prism_infilt #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [5:0]       address,
    input  logic [31:0]      data_in,
    input  logic [1:0]       data_write_n,
    output logic [31:0]      data_out,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             irq
);

    localparam logic [5:0] AddrCtrl   = 6'h00;
    localparam logic [5:0] AddrStatus = 6'h04;
    localparam logic [5:0] AddrIe     = 6'h08;

    logic                        wr_en;
    logic                        ctrl_wr;
    logic                        status_wr;
    logic                        ie_wr;

    logic [WIDTH-1:0]            filt_en_q;
    logic [WIDTH-1:0]            invert_q;
    logic [CNT_W-1:0]            thresh_q;
    logic [WIDTH-1:0]            rise_ie_q;
    logic [WIDTH-1:0]            fall_ie_q;

    logic [WIDTH-1:0]            raw;
    logic [WIDTH-1:0]            filt_q;
    logic [WIDTH-1:0]            filt_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0]            rise_q;
    logic [WIDTH-1:0]            rise_d;
    logic [WIDTH-1:0]            fall_q;
    logic [WIDTH-1:0]            fall_d;
    logic [WIDTH-1:0]            rise_flag_q;
    logic [WIDTH-1:0]            rise_flag_d;
    logic [WIDTH-1:0]            fall_flag_q;
    logic [WIDTH-1:0]            fall_flag_d;
    logic [WIDTH-1:0]            rise_clr;
    logic [WIDTH-1:0]            fall_clr;

    // Only full 32-bit writes commit.
    assign wr_en     = (data_write_n == 2'b10);
    assign ctrl_wr   = wr_en && (address == AddrCtrl);
    assign status_wr = wr_en && (address == AddrStatus);
    assign ie_wr     = wr_en && (address == AddrIe);

    assign raw = pin_in ^ invert_q;

    // Configuration registers: CTRL and IE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_en_q <= '0;
            invert_q  <= '0;
            thresh_q  <= '0;
            rise_ie_q <= '0;
            fall_ie_q <= '0;
        end else begin
            if (ctrl_wr) begin
                filt_en_q <= data_in[WIDTH-1:0];
                invert_q  <= data_in[8 +: WIDTH];
                thresh_q  <= data_in[16 +: CNT_W];
            end
            if (ie_wr) begin
                rise_ie_q <= data_in[WIDTH-1:0];
                fall_ie_q <= data_in[8 +: WIDTH];
            end
        end
    end

    // Per-channel stability filter; a CTRL write restarts every count without touching levels.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (!filt_en_q[i]) begin
                filt_d[i] = raw[i];
                cnt_d[i]  = '0;
            end else if (ctrl_wr || (raw[i] == filt_q[i])) begin
                cnt_d[i]  = '0;
            end else if (cnt_q[i] == thresh_q) begin
                filt_d[i] = raw[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i]  = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edge pulses line up with the cycle the filtered level changes; flags are set-dominant W1C.
    always_comb begin
        rise_d      = filt_d & ~filt_q;
        fall_d      = ~filt_d & filt_q;
        rise_clr    = {WIDTH{status_wr}} & data_in[8 +: WIDTH];
        fall_clr    = {WIDTH{status_wr}} & data_in[16 +: WIDTH];
        rise_flag_d = (rise_flag_q & ~rise_clr) | rise_q;
        fall_flag_d = (fall_flag_q & ~fall_clr) | fall_q;
    end

    // Filter, pulse and flag state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q      <= '0;
            cnt_q       <= '0;
            rise_q      <= '0;
            fall_q      <= '0;
            rise_flag_q <= '0;
            fall_flag_q <= '0;
        end else begin
            filt_q      <= filt_d;
            cnt_q       <= cnt_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            rise_flag_q <= rise_flag_d;
            fall_flag_q <= fall_flag_d;
        end
    end

    // Combinational read mux; unmapped addresses read as zero.
    always_comb begin
        data_out = '0;
        case (address)
            AddrCtrl: begin
                data_out[WIDTH-1:0]   = filt_en_q;
                data_out[8 +: WIDTH]  = invert_q;
                data_out[16 +: CNT_W] = thresh_q;
            end
            AddrStatus: begin
                data_out[WIDTH-1:0]   = filt_q;
                data_out[8 +: WIDTH]  = rise_flag_q;
                data_out[16 +: WIDTH] = fall_flag_q;
            end
            AddrIe: begin
                data_out[WIDTH-1:0]   = rise_ie_q;
                data_out[8 +: WIDTH]  = fall_ie_q;
            end
            default: data_out = '0;
        endcase
    end

    assign filt_out   = filt_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign irq        = |((rise_flag_q & rise_ie_q) | (fall_flag_q & fall_ie_q));

endmodule

// File: tb/tb_tqvp_prism_infilt.sv
// Scoreboard bench for tqvp_prism_infilt: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_tqvp_prism_infilt;

    localparam int SelDout = 0;
    localparam int SelFilt = 1;
    localparam int SelRise = 2;
    localparam int SelFall = 3;
    localparam int SelIrq  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pin_in;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [31:0] data_out;
    logic [7:0]  filt_out;
    logic [7:0]  rise_pulse;
    logic [7:0]  fall_pulse;
    logic        irq;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    tqvp_prism_infilt #(
        .WIDTH(8),
        .CNT_W(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pin_in      (pin_in),
        .address     (address),
        .data_in     (data_in),
        .data_write_n(data_write_n),
        .data_out    (data_out),
        .filt_out    (filt_out),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    function automatic void push_exp(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        sb.push_back(e);
    endfunction

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            SelDout: return data_out;
            SelFilt: return {24'h0, filt_out};
            SelRise: return {24'h0, rise_pulse};
            SelFall: return {24'h0, fall_pulse};
            default: return {31'h0, irq};
        endcase
    endfunction

    // Monitor: every expectation queued during a cycle is checked at that cycle's negedge.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                exp_t        e;
                logic [31:0] a;
                e = sb.pop_front();
                a = actual(e.sel);
                total++;
                if (a !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
        address      = a;
        data_in      = d;
        data_write_n = wn;
        step();
        data_write_n = 2'b11;
    endtask

    task automatic rd(input string name, input logic [5:0] a, input logic [31:0] v);
        address = a;
        push_exp(name, SelDout, v);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        pin_in       = 8'h00;
        address      = 6'h00;
        data_in      = 32'h0;
        data_write_n = 2'b11;
        step();
        step();
        push_exp("rst_filt", SelFilt, 32'h0);
        push_exp("rst_rise", SelRise, 32'h0);
        push_exp("rst_fall", SelFall, 32'h0);
        push_exp("rst_irq",  SelIrq,  32'h0);
        step();
        rst = 1'b0;

        // Register reset values, then unfiltered passthrough of all channels.
        rd("rd_ctrl_rst",   6'h00, 32'h0);
        rd("rd_status_rst", 6'h04, 32'h0);
        rd("rd_ie_rst",     6'h08, 32'h0);
        pin_in = 8'hFF;
        step();
        push_exp("pass_filt", SelFilt, 32'hFF);
        push_exp("pass_rise", SelRise, 32'hFF);
        step();
        push_exp("pass_rise_end", SelRise, 32'h00);
        rd("pass_status", 6'h04, 32'h0000_FFFF);
        pin_in = 8'h00;
        step();
        push_exp("pass_fall", SelFall, 32'hFF);
        push_exp("pass_filt0", SelFilt, 32'h00);
        step();
        wr(6'h04, 32'h00FF_FF00, 2'b10);
        rd("status_cleared", 6'h04, 32'h0);

        // Channel 0 filtered with thresh 3: a 3-cycle glitch is rejected, 4 stable cycles pass.
        wr(6'h00, 32'h0003_0001, 2'b10);
        pin_in = 8'h01;
        for (int i = 0; i < 3; i++) begin
            step();
            push_exp("glitch_filt", SelFilt, 32'h00);
            push_exp("glitch_rise", SelRise, 32'h00);
        end
        pin_in = 8'h00;
        step();
        push_exp("glitch_after", SelFilt, 32'h00);
        step();
        step();
        pin_in = 8'h01;
        for (int i = 0; i < 3; i++) begin
            step();
            push_exp("stable_early", SelFilt, 32'h00);
        end
        step();
        push_exp("stable_filt", SelFilt, 32'h01);
        push_exp("stable_rise", SelRise, 32'h01);
        step();
        push_exp("stable_rise_end", SelRise, 32'h00);
        wr(6'h04, 32'h0000_0100, 2'b10);

        // Interrupt on channel 2 rise, W1C clear, and set-wins on a coincident clear.
        wr(6'h08, 32'h0000_0004, 2'b10);
        pin_in = 8'h05;
        step();
        push_exp("irq_rise", SelRise, 32'h04);
        push_exp("irq_not_yet", SelIrq, 32'h0);
        step();
        push_exp("irq_set", SelIrq, 32'h1);
        wr(6'h04, 32'h0000_0400, 2'b10);
        push_exp("irq_cleared", SelIrq, 32'h0);
        pin_in = 8'h01;
        step();
        push_exp("ch2_fall", SelFall, 32'h04);
        pin_in = 8'h05;
        step();
        push_exp("ch2_rise_again", SelRise, 32'h04);
        wr(6'h04, 32'h0000_0400, 2'b10);
        push_exp("set_wins_irq", SelIrq, 32'h1);
        rd("set_wins_status", 6'h04, 32'h0004_0405);
        wr(6'h04, 32'h00FF_FF00, 2'b10);
        push_exp("irq_all_clear", SelIrq, 32'h0);

        // Inverting unfiltered channel 5 with its pin low gives a rising edge.
        wr(6'h00, 32'h0003_2001, 2'b10);
        step();
        push_exp("inv_rise", SelRise, 32'h20);
        push_exp("inv_fall", SelFall, 32'h00);
        push_exp("inv_filt", SelFilt, 32'h25);
        step();
        push_exp("inv_rise_end", SelRise, 32'h00);
        wr(6'h04, 32'h00FF_FF00, 2'b10);

        // Channel 1 thresh 7: a CTRL write at count 4 restarts the count.
        wr(6'h00, 32'h0007_2003, 2'b10);
        pin_in = 8'h07;
        for (int i = 0; i < 4; i++) begin
            step();
            push_exp("cnt_pre_wr", SelFilt, 32'h25);
        end
        wr(6'h00, 32'h0007_2003, 2'b10);
        push_exp("cnt_at_wr", SelFilt, 32'h25);
        for (int i = 0; i < 7; i++) begin
            step();
            push_exp("cnt_restart_filt", SelFilt, 32'h25);
            push_exp("cnt_restart_rise", SelRise, 32'h00);
        end
        step();
        push_exp("cnt_edge_filt", SelFilt, 32'h27);
        push_exp("cnt_edge_rise", SelRise, 32'h02);

        // Reset mid-count: outputs clear without a clock edge, no pulse after release.
        pin_in = 8'h05;
        step();
        step();
        step();
        rst     = 1'b1;
        address = 6'h00;
        pin_in  = 8'h00;
        push_exp("async_filt", SelFilt, 32'h00);
        push_exp("async_rise", SelRise, 32'h00);
        push_exp("async_fall", SelFall, 32'h00);
        push_exp("async_irq",  SelIrq,  32'h0);
        push_exp("async_ctrl", SelDout, 32'h0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            push_exp("post_rst_filt", SelFilt, 32'h00);
            push_exp("post_rst_rise", SelRise, 32'h00);
            push_exp("post_rst_fall", SelFall, 32'h00);
        end

        // Non-32-bit writes are ignored; unmapped reads return zero.
        wr(6'h00, 32'h000F_00FF, 2'b00);
        rd("ignored_write", 6'h00, 32'h0);
        wr(6'h00, 32'h000F_00FF, 2'b01);
        rd("ignored_write_01", 6'h00, 32'h0);
        rd("unmapped_read", 6'h3C, 32'h0);

        step();
        step();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tqvp_prism_infilt.md
Name: tqvp_prism_infilt

Overview:
- Input conditioning stage directly upstream of the PRISM peripheral.
- Takes the already-synchronized ui_in pins and applies, per channel, optional polarity inversion and a programmable-length glitch filter.
- Produces registered, filtered levels plus single-cycle rise/fall pulses, which drive the PRISM in_data inputs.
- Keeps sticky edge flags with an interrupt, accessed through the same TinyQV peripheral register bus style.

Parameters:
- WIDTH, 8, number of input channels filtered.
- CNT_W, 4, width of the filter threshold and of each per-channel stability counter.

Ports:
- clk  input  1  system clock (TinyQV project clock).
- rst  input  1  asynchronous, active-high reset.
- pin_in  input  WIDTH  synchronized raw inputs.
- address  input  6  register address within the block.
- data_in  input  32  write data.
- data_write_n  input  2  11 = no write; only 2'b10 (32-bit) commits a write.
- data_out  output  32  combinational read data for the current address.
- filt_out  output  WIDTH  registered filtered levels.
- rise_pulse  output  WIDTH  one-cycle pulse per channel on a filtered 0->1 transition.
- fall_pulse  output  WIDTH  one-cycle pulse per channel on a filtered 1->0 transition.
- irq  output  1  level interrupt: OR over (rise_flag & rise_ie) | (fall_flag & fall_ie).

Behaviour:
- Reset (rst high, asynchronous): all registers, counters and flags go to 0. Outputs at reset: filt_out = 0, rise_pulse = 0, fall_pulse = 0, irq = 0.
- Register map (32-bit writes only; unmapped reads return 0):
  - 0x00 CTRL: [WIDTH-1:0] filt_en, [8+WIDTH-1:8] invert, [16+CNT_W-1:16] thresh.
  - 0x04 STATUS: [WIDTH-1:0] filt_out (read only), [8+WIDTH-1:8] rise_flag, [16+WIDTH-1:16] fall_flag. Flags are write-1-to-clear.
  - 0x08 IE: [WIDTH-1:0] rise_ie, [8+WIDTH-1:8] fall_ie.
- Per channel i: raw = pin_in[i] ^ invert[i].
- Channel with filt_en[i] = 0: filt[i] <= raw every cycle (1-cycle latency); counter held at 0.
- Channel with filt_en[i] = 1:
  - If raw == filt[i], cnt <= 0.
  - Else, if cnt == thresh, then filt[i] <= raw and cnt <= 0.
  - Else, cnt <= cnt + 1.
  - Result: a change stable for thresh+1 consecutive cycles appears on filt_out thresh+1 cycles after the first sampled cycle. thresh = 0 gives a 1-cycle latency.
  - Any shorter pulse is rejected and restarts the count.
  - The counter never wraps: it is reset at the thresh match and is compared with equality.
- Edge pulses:
  - rise_pulse[i] and fall_pulse[i] are registered and are high in the same cycle filt_out[i] shows its new value, for exactly one cycle.
  - They are mutually exclusive per channel.
- Flags:
  - A pulse sets the matching flag.
  - Set and write-1-clear in the same cycle: set wins.
  - Writing 0 bits leaves flags unchanged.
- irq is combinational from the registered flags and enables: it asserts the cycle after the pulse and drops the cycle after the clear.
- A CTRL write clears all stability counters the following cycle; filt_out is not modified.
- Changing invert is treated as an input change and is filtered normally, e.g. toggling invert on an enabled channel yields an edge after thresh+1 cycles.
- Writes with data_write_n != 2'b10 are ignored.
- Assertion of rst mid-filtering aborts the count immediately; no pulse is generated on reset release.

Test Plan:
- Reset, then read 0x00/0x04/0x08 -> all 0; filt_out = 0, irq = 0. Drive pin_in = 8'hFF with filt_en = 0 -> filt_out = 8'hFF one cycle later; rise_pulse = 8'hFF for one cycle; STATUS[15:8] = 8'hFF.
- CTRL: filt_en[0] = 1, thresh = 3. A 3-cycle high glitch on pin_in[0] -> filt_out[0] stays 0, no rise_pulse. A 4-cycle-stable high -> filt_out[0] = 1 exactly 4 cycles after the first high sample.
- IE: rise_ie[2] = 1; rising edge on channel 2 -> irq high the cycle after rise_pulse[2]. Write 0x04 with bit 10 = 1 -> irq low next cycle. Clear coincident with a new rise_pulse[2] -> flag stays 1.
- invert[5] = 1 with pin_in[5] = 0, filt_en[5] = 0 -> fall_pulse absent, rise_pulse[5] after 1 cycle, filt_out[5] = 1.
- Channel 1 mid-count (thresh = 7, cnt = 4): issue a CTRL write -> count restarts, edge appears 8 cycles after the write. Assert rst mid-count -> all outputs 0 asynchronously, no pulses after release.
- Write 0x00 with data_write_n = 2'b00 -> CTRL unchanged. Read 0x3C -> 0.
